// File: rtl/sine_phase_nco_if.sv
// Voice-side bundle for the sine NCO: tick/tuning/gate in, ROM port and sample out.
// The slave modport is the NCO; the master side is the sequencer, the ROM and the sample sink.
interface sine_phase_nco_if #(
    parameter int PHASE_W = 24
);
    logic               sample_tick;
    logic [PHASE_W-1:0] tuning_word;
    logic               gate;
    logic [7:0]         rom_address;
    logic [11:0]        rom_q;
    logic [11:0]        sample_out;
    logic               sample_valid;
    logic               active;
    logic               overrun;

    modport slave (
        input  sample_tick, tuning_word, gate, rom_q,
        output rom_address, sample_out, sample_valid, active, overrun
    );

    modport master (
        output sample_tick, tuning_word, gate, rom_q,
        input  rom_address, sample_out, sample_valid, active, overrun
    );
endinterface

// File: rtl/sine_phase_nco.sv
// Phase-accumulator sine voice: tick -> ROM fetch -> sample, sample_valid 4 clocks after the tick.
// No backpressure: ticks arriving while busy are dropped and latched into the sticky overrun flag.
module sine_phase_nco #(
    parameter int PHASE_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    sine_phase_nco_if.slave   nco
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, EMIT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W:0]   w_sum;
    logic               w_accept;
    logic               w_release;
    logic [7:0]         r_rom_address;
    logic [11:0]        r_sample;
    logic               r_valid;
    logic               r_active;
    logic               r_overrun;

    assign w_accept  = (r_state == IDLE) && nco.sample_tick;
    assign w_sum     = {1'b0, r_phase} + {1'b0, nco.tuning_word};
    // A released note runs until the phase wraps, so it stops on a zero crossing.
    assign w_release = r_active && !nco.gate &&
                       (w_sum[PHASE_W] || (nco.tuning_word == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (nco.sample_tick) w_next = FETCH;
            FETCH:   w_next = WAIT;
            WAIT:    w_next = EMIT;
            EMIT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase       <= '0;
            r_rom_address <= '0;
            r_sample      <= '0;
            r_valid       <= 1'b0;
            r_active      <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if ((r_state != IDLE) && nco.sample_tick) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                if (!r_active) begin
                    r_phase  <= '0;
                    r_active <= nco.gate;
                end else if (w_release) begin
                    r_phase  <= '0;
                    r_active <= 1'b0;
                end else begin
                    r_phase <= w_sum[PHASE_W-1:0];
                end
            end
            if (r_state == FETCH) begin
                r_rom_address <= r_phase[PHASE_W-1 -: 8];
            end
            // ROM data is offset-binary; flipping the MSB yields two's complement.
            if (r_state == EMIT) begin
                r_sample <= r_active ? {~nco.rom_q[11], nco.rom_q[10:0]} : 12'h000;
                r_valid  <= 1'b1;
            end
        end
    end

    assign nco.rom_address  = r_rom_address;
    assign nco.sample_out   = r_sample;
    assign nco.sample_valid = r_valid;
    assign nco.active       = r_active;
    assign nco.overrun      = r_overrun;
endmodule

// File: tb/tb_sine_phase_nco.sv
// Bench for sine_phase_nco: vector table, hand-written corner sequences, and random ticks vs a model.
module tb_sine_phase_nco;
    localparam int PHASE_W = 24;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    sine_phase_nco_if #(.PHASE_W(PHASE_W)) nco_bus ();

    sine_phase_nco #(.PHASE_W(PHASE_W)) dut (
        .clock (clock),
        .reset (reset),
        .nco   (nco_bus)
    );

    always #5 clock = ~clock;

    logic [11:0] rom_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 12'(i * 16);
    end
    always @(posedge clock) nco_bus.rom_q <= rom_mem[nco_bus.rom_address];

    typedef struct {
        bit          rst_before;
        bit          gate;
        logic [23:0] tw;
        logic [7:0]  exp_addr;
        logic [11:0] exp_sample;
        bit          exp_active;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        nco_bus.sample_tick = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clock);
            if (nco_bus.sample_valid) seen = 1'b1;
        end
    endtask

    task automatic do_tick(input string name, input bit g, input logic [23:0] tw,
                           input logic [7:0] ea, input logic [11:0] es, input bit eact);
        bit seen;
        @(negedge clock);
        nco_bus.sample_tick = 1'b1;
        nco_bus.gate        = g;
        nco_bus.tuning_word = tw;
        @(negedge clock);
        nco_bus.sample_tick = 1'b0;
        wait_valid(seen);
        check({name, "_valid_seen"}, 32'(seen), 32'd1);
        check({name, "_addr"}, 32'(nco_bus.rom_address), 32'(ea));
        check({name, "_sample"}, 32'(nco_bus.sample_out), 32'(es));
        check({name, "_active"}, 32'(nco_bus.active), 32'(eact));
        @(negedge clock);
        check({name, "_valid_one_cycle"}, 32'(nco_bus.sample_valid), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    function automatic void add(bit r, bit g, logic [23:0] tw, logic [7:0] a, logic [11:0] s, bit act);
        vec_t v;
        v.rst_before = r; v.gate = g; v.tw = tw;
        v.exp_addr = a; v.exp_sample = s; v.exp_active = act;
        vecs.push_back(v);
    endfunction

    longint m_phase;
    bit     m_active;

    initial begin
        nco_bus.sample_tick = 1'b0;
        nco_bus.gate        = 1'b0;
        nco_bus.tuning_word = '0;

        // steady tone
        add(1, 1, 24'h010000, 8'd0, 12'h800, 1);
        add(0, 1, 24'h010000, 8'd1, 12'h810, 1);
        add(0, 1, 24'h010000, 8'd2, 12'h820, 1);
        add(0, 1, 24'h010000, 8'd3, 12'h830, 1);
        // release running to wrap
        add(1, 1, 24'h400000, 8'd0,   12'h800, 1);
        add(0, 1, 24'h400000, 8'd64,  12'hC00, 1);
        add(0, 0, 24'h400000, 8'd128, 12'h000, 1);
        add(0, 0, 24'h400000, 8'd192, 12'h400, 1);
        add(0, 0, 24'h400000, 8'd0,   12'h000, 0);
        // gate reasserted before the wrap keeps running through it
        add(1, 1, 24'h400000, 8'd0,   12'h800, 1);
        add(0, 0, 24'h400000, 8'd64,  12'hC00, 1);
        add(0, 1, 24'h400000, 8'd128, 12'h000, 1);
        add(0, 1, 24'h400000, 8'd192, 12'h400, 1);
        add(0, 1, 24'h400000, 8'd0,   12'h800, 1);
        // zero tuning word release, then idle ticks with gate low
        add(1, 1, 24'h000000, 8'd0, 12'h800, 1);
        add(0, 1, 24'h000000, 8'd0, 12'h800, 1);
        add(0, 0, 24'h000000, 8'd0, 12'h000, 0);
        add(0, 0, 24'h000000, 8'd0, 12'h000, 0);
        add(1, 0, 24'h123456, 8'd0, 12'h000, 0);

        // reset state, observed while reset is still held
        @(negedge clock);
        @(negedge clock);
        check("rst_addr",    32'(nco_bus.rom_address),  32'd0);
        check("rst_sample",  32'(nco_bus.sample_out),   32'd0);
        check("rst_valid",   32'(nco_bus.sample_valid), 32'd0);
        check("rst_active",  32'(nco_bus.active),       32'd0);
        check("rst_overrun", 32'(nco_bus.overrun),      32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            do_tick($sformatf("vec%0d", i), vecs[i].gate, vecs[i].tw,
                    vecs[i].exp_addr, vecs[i].exp_sample, vecs[i].exp_active);
        end

        // latency: valid only in cycle 4 after the tick
        do_reset();
        @(negedge clock);
        nco_bus.sample_tick = 1'b1;
        nco_bus.gate        = 1'b1;
        nco_bus.tuning_word = 24'h010000;
        @(negedge clock);
        nco_bus.sample_tick = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check($sformatf("latency_cyc%0d", k + 1), 32'(nco_bus.sample_valid), (k == 3) ? 32'd1 : 32'd0);
        end

        // overrun: two back-to-back ticks give one pulse; flag stays set
        do_reset();
        begin
            int pulses = 0;
            @(negedge clock);
            nco_bus.sample_tick = 1'b1;
            nco_bus.gate        = 1'b1;
            @(negedge clock);
            @(negedge clock);
            nco_bus.sample_tick = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (nco_bus.sample_valid) pulses++;
                @(negedge clock);
            end
            check("overrun_pulses", 32'(pulses), 32'd1);
            check("overrun_set", 32'(nco_bus.overrun), 32'd1);
        end
        do_tick("overrun_later", 1, 24'h010000, 8'd1, 12'h810, 1);
        check("overrun_sticky", 32'(nco_bus.overrun), 32'd1);

        // reset while in WAIT, then a tick in the first cycle after reset
        do_reset();
        do_tick("mid_a", 1, 24'h010000, 8'd0, 12'h800, 1);
        do_tick("mid_b", 1, 24'h010000, 8'd1, 12'h810, 1);
        @(negedge clock);
        nco_bus.sample_tick = 1'b1;
        @(negedge clock);
        nco_bus.sample_tick = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_addr",    32'(nco_bus.rom_address),  32'd0);
        check("mid_rst_sample",  32'(nco_bus.sample_out),   32'd0);
        check("mid_rst_valid",   32'(nco_bus.sample_valid), 32'd0);
        check("mid_rst_active",  32'(nco_bus.active),       32'd0);
        check("mid_rst_overrun", 32'(nco_bus.overrun),      32'd0);
        nco_bus.sample_tick = 1'b1;
        nco_bus.gate        = 1'b1;
        @(negedge clock);
        nco_bus.sample_tick = 1'b0;
        check("mid_no_stale_valid", 32'(nco_bus.sample_valid), 32'd0);
        begin
            bit seen;
            wait_valid(seen);
            check("mid_restart_seen", 32'(seen), 32'd1);
            check("mid_restart_addr", 32'(nco_bus.rom_address), 32'd0);
            check("mid_restart_sample", 32'(nco_bus.sample_out), 32'h800);
        end

        // random ticks against the note model
        do_reset();
        m_phase  = 0;
        m_active = 0;
        for (int n = 0; n < 80; n++) begin
            bit          g;
            logic [23:0] tw;
            longint      s;
            longint      a;
            g  = ($urandom_range(0, 3) != 0);
            tw = 24'($urandom() >> $urandom_range(8, 20));
            if ($urandom_range(0, 9) == 0) tw = '0;
            if (!m_active) begin
                m_phase  = 0;
                m_active = g;
            end else begin
                s = m_phase + longint'(tw);
                if (!g && (s >= 64'd16777216 || tw == 0)) begin
                    m_phase  = 0;
                    m_active = 0;
                end else begin
                    m_phase = s % 64'd16777216;
                end
            end
            a = m_phase / 65536;
            do_tick($sformatf("rnd%0d", n), g, tw, 8'(a),
                    m_active ? 12'((a * 16 + 2048) % 4096) : 12'h000, m_active);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
